// File: rtl/fetch_pc_unit_pkg.sv
// rtl/fetch_pc_unit_pkg.sv - shared widths and FSM state type for the fetch front end
package fetch_pc_unit_pkg;
  localparam int WORD               = 32;
  localparam int HALF_WORD          = 16;
  localparam int STALL_PIPELINE_SIG = 2;

  typedef enum logic [1:0] {
    LOAD_LO,
    LOAD_HI,
    RUN
  } fetch_state_t;
endpackage

// File: rtl/fetch_pc_unit_if.sv
// rtl/fetch_pc_unit_if.sv - loader, redirect and instruction-memory signals of the fetch unit
interface fetch_pc_unit_if;
  import fetch_pc_unit_pkg::*;

  logic                          load_byte_valid_i;
  logic [7:0]                    load_byte_i;
  logic                          load_done_i;
  logic [STALL_PIPELINE_SIG-1:0] stall_pipeline_i;
  logic                          branch_taken_i;
  logic [WORD-1:0]               branch_target_i;
  logic                          program_mem_write_en_o;
  logic [HALF_WORD-1:0]          instruction_o;
  logic [WORD-1:0]               instruction_addr_o;
  logic                          is_valid_o;
  logic                          loading_o;
  logic                          load_overflow_o;

  modport master (
    output load_byte_valid_i, load_byte_i, load_done_i, stall_pipeline_i,
           branch_taken_i, branch_target_i,
    input  program_mem_write_en_o, instruction_o, instruction_addr_o,
           is_valid_o, loading_o, load_overflow_o
  );

  modport slave (
    input  load_byte_valid_i, load_byte_i, load_done_i, stall_pipeline_i,
           branch_taken_i, branch_target_i,
    output program_mem_write_en_o, instruction_o, instruction_addr_o,
           is_valid_o, loading_o, load_overflow_o
  );
endinterface

// File: rtl/fetch_pc_unit_halfword_assembler.sv
// rtl/fetch_pc_unit_halfword_assembler.sv - pairs loader bytes into half-word writes with capacity check
module fetch_pc_unit_halfword_assembler
  import fetch_pc_unit_pkg::*;
#(
  parameter logic [WORD-1:0] RESET_PC   = 32'h0000_0000,
  parameter int              PROG_WORDS = 1024
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [7:0]           byte_i,
  input  logic                 lo_take,
  input  logic                 hi_take,
  input  logic                 pad_take,
  output logic                 wr_en,
  output logic [HALF_WORD-1:0] wr_data,
  output logic [WORD-1:0]      wr_addr,
  output logic                 overflow
);
  localparam logic [WORD-1:0] CAPACITY = WORD'(PROG_WORDS);

  logic [7:0]      lo_q;
  logic [WORD-1:0] load_addr;
  logic [WORD-1:0] slot;
  logic            in_range;

  assign slot     = (load_addr - RESET_PC) >> 1;
  assign in_range = slot < CAPACITY;

  // Once full, load_addr stops advancing so every later write is also dropped.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      lo_q      <= '0;
      load_addr <= RESET_PC;
      wr_en     <= 1'b0;
      wr_data   <= '0;
      wr_addr   <= RESET_PC;
      overflow  <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      if (lo_take) lo_q <= byte_i;
      if (hi_take || pad_take) begin
        if (in_range) begin
          wr_en     <= 1'b1;
          wr_data   <= {(hi_take ? byte_i : 8'h00), lo_q};
          wr_addr   <= load_addr;
          load_addr <= load_addr + WORD'(2);
        end else begin
          overflow <= 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/fetch_pc_unit.sv
// rtl/fetch_pc_unit.sv - program counter and boot-time loader FSM feeding instruction memory
module fetch_pc_unit
  import fetch_pc_unit_pkg::*;
#(
  parameter logic [WORD-1:0] RESET_PC   = 32'h0000_0000,
  parameter int              PROG_WORDS = 1024
) (
  input logic            clk_i,
  input logic            reset_i,
  fetch_pc_unit_if.slave bus
);
  localparam logic [WORD-1:0] PC_ALIGN = {{(WORD-1){1'b1}}, 1'b0};

  fetch_state_t         state;
  logic [WORD-1:0]      pc;
  logic                 done_pend;
  logic                 loading_q;
  logic                 lo_take;
  logic                 hi_take;
  logic                 pad_take;
  logic                 wr_en;
  logic [HALF_WORD-1:0] wr_data;
  logic [WORD-1:0]      wr_addr;
  logic                 overflow;

  // load_done_i wins over a same-cycle byte, which is then dropped.
  assign lo_take  = (state == LOAD_LO) && bus.load_byte_valid_i && !bus.load_done_i && !done_pend;
  assign hi_take  = (state == LOAD_HI) && bus.load_byte_valid_i && !bus.load_done_i;
  assign pad_take = (state == LOAD_HI) && bus.load_done_i;

  fetch_pc_unit_halfword_assembler #(
    .RESET_PC   (RESET_PC),
    .PROG_WORDS (PROG_WORDS)
  ) u_assembler (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .byte_i   (bus.load_byte_i),
    .lo_take  (lo_take),
    .hi_take  (hi_take),
    .pad_take (pad_take),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .wr_addr  (wr_addr),
    .overflow (overflow)
  );

  // An odd image parks in LOAD_LO for one cycle so the pad write lands before RUN.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state     <= LOAD_LO;
      pc        <= RESET_PC;
      done_pend <= 1'b0;
      loading_q <= 1'b1;
    end else begin
      case (state)
        LOAD_LO: begin
          if (bus.load_done_i || done_pend) begin
            state     <= RUN;
            loading_q <= 1'b0;
            done_pend <= 1'b0;
            pc        <= RESET_PC;
          end else if (bus.load_byte_valid_i) begin
            state <= LOAD_HI;
          end
        end
        LOAD_HI: begin
          if (bus.load_done_i) begin
            state     <= LOAD_LO;
            done_pend <= 1'b1;
          end else if (bus.load_byte_valid_i) begin
            state <= LOAD_LO;
          end
        end
        RUN: begin
          if (bus.branch_taken_i) begin
            pc <= bus.branch_target_i & PC_ALIGN;
          end else if (bus.stall_pipeline_i == '0) begin
            pc <= pc + WORD'(2);
          end
        end
        default: state <= LOAD_LO;
      endcase
    end
  end

  assign bus.program_mem_write_en_o = wr_en;
  assign bus.instruction_o          = wr_data;
  assign bus.instruction_addr_o     = (state == RUN) ? pc : wr_addr;
  assign bus.is_valid_o             = (state == RUN) && !bus.branch_taken_i;
  assign bus.loading_o              = loading_q;
  assign bus.load_overflow_o        = overflow;
endmodule
